p256_solinas_reducer: RTL and testbench

Parametrised, handshaked successor to the P-256 fold reducer. It takes a 512-bit product {a_high, a_low} and returns a value congruent to it mod p = 2^256 − 2^224 + 2^192 + 2^96 − 1. It iterates fold and carry passes only until the upper limbs are zero, instead of running a fixed pass count. When canonicalisation is compiled in, it also performs a final conditional subtraction so the result lies in [0, p). It sits between the 256×256 squarer/multiplier and the field-arithmetic sequencer.

---
 rtl/p256_pkg.sv | 28 ++
 rtl/p256_limb_addsub.sv | 38 +++
 rtl/p256_solinas_reducer.sv | 247 ++++++++++++++++++++++++
 tb/tb_p256_solinas_reducer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/p256_pkg.sv
// p256_pkg: shared definitions for the P-256 Solinas reducer.
//   P256       : field prime 2^256 - 2^224 + 2^192 + 2^96 - 1
//   NUM_LIMBS  : 32-bit limbs held by the accumulator (16 = 512 bits)
//   LIMB_W     : limb width in bits
//   state_t    : reducer controller states
//   p256_limb  : 32-bit word k (0..7) of P256
package p256_pkg;

    localparam int NUM_LIMBS = 16;
    localparam int LIMB_W    = 32;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        CARRY,
        CHECK,
        CANON,
        OUT
    } state_t;

    function automatic logic [LIMB_W-1:0] p256_limb(input logic [2:0] k);
        return P256[LIMB_W*k +: LIMB_W];
    endfunction

endpackage

// File: rtl/p256_limb_addsub.sv
// p256_limb_addsub: multi-lane signed add/subtract unit shared by the
// FOLD, CARRY and CANON phases of the reducer.
//   a, b  in  LANES*ACC_W  packed lane operands (lane 0 in the low bits)
//   sub   in  LANES        per-lane select: 1 = a - b - cin, 0 = a + b + cin
//   cin   in  1            carry/borrow into lane 0 (other lanes take 0)
//   y     out LANES*ACC_W  packed lane results
//   cout  out 1            sign of the lane-0 result: the borrow out of a
//                          limb subtraction, and the sign-fill of a carry
module p256_limb_addsub #(
    parameter int ACC_W = 64,
    parameter int LANES = 4
) (
    input  logic [LANES*ACC_W-1:0] a,
    input  logic [LANES*ACC_W-1:0] b,
    input  logic [LANES-1:0]       sub,
    input  logic                   cin,
    output logic [LANES*ACC_W-1:0] y,
    output logic                   cout
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [ACC_W-1:0] la;
        logic signed [ACC_W-1:0] lb;
        logic signed [ACC_W-1:0] lc;

        assign la = a[g*ACC_W +: ACC_W];
        assign lb = b[g*ACC_W +: ACC_W];
        if (g == 0) begin : g_cin
            assign lc = {{(ACC_W-1){1'b0}}, cin};
        end else begin : g_nocin
            assign lc = '0;
        end
        assign y[g*ACC_W +: ACC_W] = sub[g] ? (la - lb - lc) : (la + lb + lc);
    end

    assign cout = y[ACC_W-1];

endmodule

// File: rtl/p256_solinas_reducer.sv
// p256_solinas_reducer: reduces a 512-bit product {a_high, a_low} modulo
// the P-256 prime by repeated Solinas fold + carry passes, stopping as soon
// as the upper eight limbs are zero.
// Build option: define P256_RED_CANON_EN to add a final conditional
// subtraction of p so the result is canonical in [0, p); without it the
// result is only guaranteed to lie in [0, 2^256).
//   clk, rst_n  clock / asynchronous active-low reset
//   in_valid    in   operand present; accepted when in_ready
//   in_ready    out  high only in IDLE
//   a_high      in   product bits 511:256
//   a_low       in   product bits 255:0
//   abort       in   synchronous abort of the running job
//   out_valid   out  result valid, held until out_ready
//   out_ready   in   consumer takes the result
//   reduce_out  out  256-bit result
//   err         out  pass limit exhausted (qualified by out_valid)
//   busy        out  state is not IDLE
module p256_solinas_reducer
    import p256_pkg::*;
#(
    parameter int ACC_W      = 64,
    parameter int MAX_PASSES = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] a_high,
    input  logic [255:0] a_low,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] reduce_out,
    output logic         err,
    output logic         busy
);

    localparam int            PW    = $clog2(MAX_PASSES + 1);
    localparam logic [PW-1:0] MAX_P = PW'(MAX_PASSES);
    localparam int            XW    = ACC_W - LIMB_W;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] limb [NUM_LIMBS];
    logic signed [ACC_W-1:0] carry_q;
    logic [3:0]              cnt_q;
    logic [PW-1:0]           passes_q;
    logic                    err_q;
    logic [255:0]            res_q;
`ifdef P256_RED_CANON_EN
    logic                    borrow_q;
`endif

    logic [511:0]            a_full;
    logic [4*ACC_W-1:0]      op_a, op_b, op_y;
    logic [3:0]              op_sub;
    logic                    op_cin, op_cout;
    logic signed [ACC_W-1:0] sum0, sum1, sum2, sum3;
    logic signed [ACC_W-1:0] fold_t;
    logic [2:0]              fi;
    logic [3:0]              ix_lo, ix_t, ix_p3, ix_p6, ix_p7;
    logic                    upper_zero;
    logic [255:0]            low_word;

    assign a_full = {a_high, a_low};

    // Fold step i touches limbs i, i+3, i+6, i+7 and clears 8+i; these five
    // indices are always distinct, so all updates happen in one cycle.
    assign fi     = cnt_q[2:0];
    assign ix_lo  = {1'b0, fi};
    assign ix_t   = {1'b1, fi};
    assign ix_p3  = ix_lo + 4'd3;
    assign ix_p6  = ix_lo + 4'd6;
    assign ix_p7  = ix_lo + 4'd7;
    assign fold_t = limb[ix_t];

    assign sum0 = op_y[ACC_W-1:0];
    assign sum1 = op_y[2*ACC_W-1:ACC_W];
    assign sum2 = op_y[3*ACC_W-1:2*ACC_W];
    assign sum3 = op_y[4*ACC_W-1:3*ACC_W];

    always_comb begin
        upper_zero = 1'b1;
        for (int k = NUM_LIMBS / 2; k < NUM_LIMBS; k++) begin
            if (limb[k] != '0) upper_zero = 1'b0;
        end
    end

    always_comb begin
        low_word = '0;
        for (int k = 0; k < NUM_LIMBS / 2; k++) begin
            low_word[LIMB_W*k +: LIMB_W] = limb[k][LIMB_W-1:0];
        end
    end

    // Operand steering for the shared add/sub unit.
    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_sub = '0;
        op_cin = 1'b0;
        case (state_q)
            FOLD: begin
                op_a   = {limb[ix_p6], limb[ix_p3], limb[ix_p7], limb[ix_lo]};
                op_b   = {4{fold_t}};
                op_sub = 4'b1100;
            end
            CARRY: begin
                op_a[ACC_W-1:0] = limb[cnt_q];
                op_b[ACC_W-1:0] = carry_q;
            end
`ifdef P256_RED_CANON_EN
            CANON: begin
                op_a[ACC_W-1:0] = {{XW{1'b0}}, limb[ix_lo][LIMB_W-1:0]};
                op_b[ACC_W-1:0] = {{XW{1'b0}}, p256_limb(fi)};
                op_sub          = 4'b0001;
                op_cin          = borrow_q;
            end
`endif
            default: ;
        endcase
    end

    p256_limb_addsub #(
        .ACC_W (ACC_W),
        .LANES (4)
    ) u_addsub (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .cin  (op_cin),
        .y    (op_y),
        .cout (op_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = FOLD;
            FOLD:  if (cnt_q == 4'd7) state_d = CARRY;
            CARRY: if (cnt_q == 4'd15) state_d = CHECK;
            CHECK: begin
                if (upper_zero) begin
`ifdef P256_RED_CANON_EN
                    state_d = CANON;
`else
                    state_d = OUT;
`endif
                end else if (passes_q < MAX_P) begin
                    state_d = FOLD;
                end else begin
                    state_d = OUT;
                end
            end
            CANON: if (fi == 3'd7) state_d = OUT;
            OUT:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // Datapath. An aborted job leaves stale limbs behind; the next accept
    // reloads everything, so abort needs no datapath action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LIMBS; k++) limb[k] <= '0;
            carry_q  <= '0;
            cnt_q    <= '0;
            passes_q <= '0;
            err_q    <= 1'b0;
            res_q    <= '0;
`ifdef P256_RED_CANON_EN
            borrow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NUM_LIMBS; k++) begin
                            limb[k] <= {{XW{1'b0}}, a_full[LIMB_W*k +: LIMB_W]};
                        end
                        carry_q  <= '0;
                        cnt_q    <= '0;
                        passes_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                FOLD: begin
                    limb[ix_lo] <= sum0;
                    limb[ix_p7] <= sum1;
                    limb[ix_p3] <= sum2;
                    limb[ix_p6] <= sum3;
                    limb[ix_t]  <= '0;
                    cnt_q       <= (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
                end
                CARRY: begin
                    // Top limb keeps the full signed sum so no value is lost.
                    if (cnt_q == 4'd15) begin
                        limb[15] <= sum0;
                        carry_q  <= '0;
                        passes_q <= passes_q + 1'b1;
                    end else begin
                        limb[cnt_q] <= {{XW{1'b0}}, sum0[LIMB_W-1:0]};
                        carry_q     <= {{LIMB_W{op_cout}}, sum0[ACC_W-1:LIMB_W]};
                    end
                    cnt_q <= cnt_q + 4'd1;
                end
                CHECK: begin
                    cnt_q <= '0;
`ifdef P256_RED_CANON_EN
                    borrow_q <= 1'b0;
`endif
                    if (upper_zero) begin
`ifndef P256_RED_CANON_EN
                        res_q <= low_word;
`endif
                    end else if (passes_q >= MAX_P) begin
                        err_q <= 1'b1;
                        res_q <= low_word;
                    end
                end
`ifdef P256_RED_CANON_EN
                CANON: begin
                    // res_q collects D = V - p limb by limb; a final borrow
                    // means V < p, so V itself is kept instead.
                    borrow_q <= op_cout;
                    if (fi == 3'd7 && op_cout) res_q <= low_word;
                    else                       res_q[LIMB_W*fi +: LIMB_W] <= sum0[LIMB_W-1:0];
                    cnt_q <= (fi == 3'd7) ? 4'd0 : cnt_q + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == OUT);
    assign reduce_out = res_q;
    assign err        = err_q;

endmodule

// File: tb/tb_p256_solinas_reducer.sv
// tb_p256_solinas_reducer: randomized self-checking bench for the P-256
// Solinas reducer, with a bignum reference model of the pass sequence.
// Follows the P256_RED_CANON_EN build option of the RTL.
module tb_p256_solinas_reducer;

    localparam logic [255:0] P_REF =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] K_2_256 =
        256'h00000000_FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000000_00000001;
`ifdef P256_RED_CANON_EN
    localparam bit CANON_EN = 1'b1;
`else
    localparam bit CANON_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [255:0] a_high = '0, a_low = '0;
    logic         in_ready, out_valid, err, busy;
    logic [255:0] reduce_out;
    logic         in_valid1 = 1'b0, abort1 = 1'b0, out_ready1 = 1'b0;
    logic         in_ready1, out_valid1, err1, busy1;
    logic [255:0] reduce_out1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    p256_solinas_reducer u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_high(a_high), .a_low(a_low), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .reduce_out(reduce_out), .err(err), .busy(busy)
    );

    p256_solinas_reducer #(.MAX_PASSES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_high(a_high), .a_low(a_low), .abort(abort1), .out_valid(out_valid1),
        .out_ready(out_ready1), .reduce_out(reduce_out1), .err(err1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each pass subtracts floor(V / 2^256) * p; stop once V < 2^256.
    function automatic void model(input logic [511:0] x, input int maxp,
                                  output logic [255:0] r, output bit e, output int np);
        logic [575:0] v, h;
        v  = {64'd0, x};
        e  = 1'b0;
        np = 0;
        for (int it = 0; it < 64; it++) begin
            h  = v >> 256;
            v  = v - h * {320'd0, P_REF};
            np = np + 1;
            if ((v >> 256) == 0) break;
            if (np >= maxp) begin
                e = 1'b1;
                break;
            end
        end
        r = v[255:0];
        if (CANON_EN && !e && r >= P_REF) r = r - P_REF;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_job(input logic [255:0] hi, input logic [255:0] lo,
                           input int hold, input bit poke,
                           input bit use_want, input logic [255:0] want, input string tag);
        logic [255:0] er;
        bit           ee;
        int           np, n_exp, cyc;
        model({hi, lo}, 12, er, ee, np);
        if (use_want) er = want;
        n_exp = 25 * np + ((CANON_EN && !ee) ? 8 : 0);
        cyc = 0;
        while (!in_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_idle"}, 256'(in_ready), 256'(1));
        a_high   = hi;
        a_low    = lo;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_inready_low"}, 256'(in_ready), 256'(0));
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            if (poke && cyc == 5) begin
                in_valid = 1'b1;
                a_high   = ~hi;
                a_low    = ~lo;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 256'(cyc), 256'(n_exp));
        chk({tag, "_valid"}, 256'(out_valid), 256'(1));
        chk({tag, "_err"}, 256'(err), 256'(ee));
        chk({tag, "_result"}, reduce_out, er);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 256'(out_valid), 256'(1));
            chk({tag, "_hold_result"}, reduce_out, er);
            chk({tag, "_hold_err"}, 256'(err), 256'(ee));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 256'(out_valid), 256'(0));
        chk({tag, "_ready_back"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        logic [255:0] x, y, pm1;
        logic [511:0] pr;
        bit           seen;
        int           cyc, mode;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_result", reduce_out, '0);
        chk("rst1_in_ready", 256'(in_ready1), 256'(1));
        rst_n = 1'b1;
        @(negedge clk);

        run_job('0, '0, 0, 1'b0, 1'b1, '0, "zero");
        run_job('0, P_REF, 0, 1'b0, 1'b1, CANON_EN ? 256'd0 : P_REF, "eq_p");
        x = '1;
        run_job('0, x, 0, 1'b0, 1'b1, CANON_EN ? (K_2_256 - 256'd1) : x, "all_ones");
        run_job(256'd1, '0, 0, 1'b0, 1'b1, K_2_256, "two_256");
        pm1 = P_REF - 256'd1;
        pr  = {256'd0, pm1} * {256'd0, pm1};
        run_job(pr[511:256], pr[255:0], 5, 1'b1, 1'b0, '0, "pm1_sq");

        for (int j = 0; j < 300; j++) begin
            mode = $urandom_range(0, 2);
            x = rnd256();
            y = rnd256();
            if (mode == 0) begin
                pr = {256'd0, x} * {256'd0, y};
            end else if (mode == 1) begin
                pr = {x >> $urandom_range(0, 255), y};
            end else begin
                pr = {224'd0, x[31:0] & {32{x[32]}}, y};
            end
            run_job(pr[511:256], pr[255:0], (j % 25 == 0) ? 5 : 0,
                    (j % 10 == 3), 1'b0, '0, "rand");
        end

        // Abort partway through a job.
        a_high   = rnd256();
        a_low    = rnd256();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_in_ready", 256'(in_ready), 256'(1));
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_out", 256'(seen), 256'(0));
        run_job(rnd256(), rnd256(), 0, 1'b0, 1'b0, '0, "after_abort");

        // Asynchronous reset in the middle of CARRY.
        a_high   = rnd256();
        a_low    = rnd256();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_err", 256'(err), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_result", reduce_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job('0, P_REF, 0, 1'b0, 1'b1, CANON_EN ? 256'd0 : P_REF, "after_rst");

        // Pass limit of one on a large upper half.
        a_high    = '1;
        a_low     = rnd256();
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("maxp1_latency", 256'(cyc), 256'(25));
        chk("maxp1_valid", 256'(out_valid1), 256'(1));
        chk("maxp1_err", 256'(err1), 256'(1));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("maxp1_drop", 256'(out_valid1), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
